data_memory: RTL and testbench

Parametrised, byte-addressed, big-endian data memory for the ARM pipeline's MEM stage. It replaces the fixed-width, zero-latency word memory with a request/response handshake, programmable wait states, byte/halfword/word access with sign extension, and range/alignment error reporting. The window is mapped at `BASE_ADDR` (default 1024). The byte at the lowest address is the most significant byte of a word.

---
 rtl/arm_mem_pkg.sv | 31 +++
 rtl/dmem_lane_steer.sv | 58 +++++
 rtl/data_memory.sv | 218 +++++++++++++++++++++
 tb/tb_data_memory.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg
// Types and constants shared by the ARM pipeline memories.
//   mem_size_t   : access size encoding carried on req_size (2'b11 is reserved)
//   dmem_state_t : handshake state of the data memory
//   MEM_BYTE_W   : width of one addressable memory location
//   size_bytes() : number of bytes touched by an access of a given size
package arm_mem_pkg;

  localparam int MEM_BYTE_W = 8;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } dmem_state_t;

  // The reserved encoding reports 4 bytes; it is rejected separately anyway.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_steer.sv
// dmem_lane_steer
// Combinational big-endian lane steering, shared by the data memory and a
// future instruction memory. Lane 0 is always the byte at the access offset
// and sits in bits [31:24] of both windows.
//   size      in  access size (mem_size_t encoding, 2'b11 yields no lanes)
//   is_signed in  sign-extend byte/halfword loads
//   rd_window in  bytes m[off], m[off+1], m[off+2], m[off+3], MSB first
//   wdata     in  right-justified store data
//   ld_data   out extended load result
//   st_be     out byte enables, st_be[3] = m[off] ... st_be[0] = m[off+3]
//   st_lanes  out store bytes positioned to match st_be
module dmem_lane_steer
  import arm_mem_pkg::*;
(
  input  logic [1:0]              size,
  input  logic                    is_signed,
  input  logic [4*MEM_BYTE_W-1:0] rd_window,
  input  logic [4*MEM_BYTE_W-1:0] wdata,
  output logic [4*MEM_BYTE_W-1:0] ld_data,
  output logic [3:0]              st_be,
  output logic [4*MEM_BYTE_W-1:0] st_lanes
);

  logic byte_sign;
  logic half_sign;

  assign byte_sign = is_signed & rd_window[31];
  assign half_sign = is_signed & rd_window[31];

  always_comb begin
    ld_data  = '0;
    st_be    = 4'b0000;
    st_lanes = '0;
    case (size)
      BYTE: begin
        ld_data  = {{24{byte_sign}}, rd_window[31:24]};
        st_be    = 4'b1000;
        st_lanes = {wdata[7:0], 24'h0};
      end
      HALF: begin
        ld_data  = {{16{half_sign}}, rd_window[31:16]};
        st_be    = 4'b1100;
        st_lanes = {wdata[15:0], 16'h0};
      end
      WORD: begin
        ld_data  = rd_window;
        st_be    = 4'b1111;
        st_lanes = wdata;
      end
      default: begin
        ld_data  = '0;
        st_be    = 4'b0000;
        st_lanes = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// data_memory
// Byte-addressed big-endian data memory for the MEM stage with a
// request/response handshake and WAIT_STATES extra cycles per access.
// Optional feature macro: DMEM_ALIGN_CHECK_EN
//   defined     : misaligned halfword/word accesses respond with rsp_err
//   not defined : low address bits are cleared before the range check
// Ports:
//   clk, rst (synchronous, active-low)
//   req_valid/req_ready handshake; req_write, req_size, req_signed,
//   req_addr, req_wdata captured on acceptance
//   rsp_valid one-cycle pulse with rsp_rdata (0 for stores/errors) and rsp_err
module data_memory
  import arm_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_BYTES = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int                OFF_W    = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [3:0]        CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  dmem_state_t       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  // Storage array; deliberately outside reset so contents survive it.
  logic [MEM_BYTE_W-1:0] mem [DEPTH_BYTES];

  logic [ADDR_W-1:0] addr_eff;
  logic              misalign;
  logic [ADDR_W-1:0] off;
  logic [ADDR_W:0]   last_ext;
  logic              acc_err;
  logic [OFF_W-1:0]  base_idx;
  logic [31:0]       rd_window;
  logic [31:0]       ld_data;
  logic [3:0]        st_be;
  logic [31:0]       st_lanes;
  logic              commit;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Alignment handling on the captured address: either flag it or clear
  // the low bits so the access lands on its natural boundary.
  always_comb begin
    addr_eff = addr_q;
    misalign = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    if (size_q == HALF) begin
      misalign = addr_q[0];
    end else if (size_q == WORD) begin
      misalign = |addr_q[1:0];
    end
`else
    if (size_q == HALF) begin
      addr_eff[0] = 1'b0;
    end else if (size_q == WORD) begin
      addr_eff[1:0] = 2'b00;
    end
`endif
  end

  // The last byte is computed one bit wider so a large offset cannot wrap
  // back into the window.
  assign off      = addr_eff - BASE;
  assign last_ext = {1'b0, off} + (ADDR_W+1)'(size_bytes(size_q)) - (ADDR_W+1)'(1);
  assign acc_err  = (addr_eff < BASE) ||
                    (last_ext >= (ADDR_W+1)'(DEPTH_BYTES)) ||
                    (size_q == 2'b11) ||
                    misalign;
  assign base_idx = off[OFF_W-1:0];

  // Gather the four bytes starting at the offset; indices wrap inside the
  // array, which only matters for accesses already rejected by acc_err.
  always_comb begin
    rd_window = '0;
    for (int i = 0; i < 4; i++) begin
      rd_window[31-MEM_BYTE_W*i -: MEM_BYTE_W] = mem[base_idx + OFF_W'(i)];
    end
  end

  dmem_lane_steer u_lane_steer (
    .size      (size_q),
    .is_signed (sgn_q),
    .rd_window (rd_window),
    .wdata     (wdata_q),
    .ld_data   (ld_data),
    .st_be     (st_be),
    .st_lanes  (st_lanes)
  );

  // pend_q marks a captured request whose completion edge is the next one;
  // it is set on acceptance with no wait states or when the countdown ends.
  // Because the FSM is back in IDLE during that cycle, a new request can be
  // accepted on the same edge that completes the previous one.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = 1'b0;
    wr_d        = wr_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    commit      = 1'b0;

    if (pend_q) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = acc_err;
      if (!acc_err) begin
        if (wr_q) begin
          commit = 1'b1;
        end else begin
          rsp_rdata_d = ld_data;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          size_d  = req_size;
          sgn_d   = req_signed;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_STATES == 0) begin
            pend_d = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          pend_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers; reset drops any access in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      pend_q      <= 1'b0;
      wr_q        <= 1'b0;
      size_q      <= 2'b00;
      sgn_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      wr_q        <= wr_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Store commit; a reset on the completion edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst && commit) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[3-i]) begin
          mem[base_idx + OFF_W'(i)] <= st_lanes[31-MEM_BYTE_W*i -: MEM_BYTE_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory
// Scoreboard bench for data_memory. Two instances: index 0 runs with two
// wait states, index 1 with none (back-to-back traffic). Stimulus pushes
// the hand-computed response into a per-instance queue; a monitor on each
// instance pops and compares whenever rsp_valid is seen, including the
// acceptance-to-response latency. Honours DMEM_ALIGN_CHECK_EN.
module tb_data_memory;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [1:0]  req_size   [2];
  logic        req_signed [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        rsp_valid  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   checks    = 0;
  int   errors    = 0;
  int   cycle_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  data_memory #(.WAIT_STATES(2)) u_dut_ws2 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid[0]),
    .req_ready  (req_ready[0]),
    .req_write  (req_write[0]),
    .req_size   (req_size[0]),
    .req_signed (req_signed[0]),
    .req_addr   (req_addr[0]),
    .req_wdata  (req_wdata[0]),
    .rsp_valid  (rsp_valid[0]),
    .rsp_rdata  (rsp_rdata[0]),
    .rsp_err    (rsp_err[0])
  );

  data_memory #(.WAIT_STATES(0)) u_dut_ws0 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid[1]),
    .req_ready  (req_ready[1]),
    .req_write  (req_write[1]),
    .req_size   (req_size[1]),
    .req_signed (req_signed[1]),
    .req_addr   (req_addr[1]),
    .req_wdata  (req_wdata[1]),
    .rsp_valid  (rsp_valid[1]),
    .rsp_rdata  (rsp_rdata[1]),
    .rsp_err    (rsp_err[1])
  );

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Monitor body: pop the oldest expectation whenever a response appears.
  task automatic checkOutput(input int which, input logic valid, input logic [31:0] rdata,
                             input logic err);
    exp_t e;
    int   depth;
    if (valid === 1'b1) begin
      depth = (which == 0) ? exp_q0.size() : exp_q1.size();
      if (depth == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL dut%0d_unexpected_rsp actual=rsp_valid required=no_response", which);
      end else begin
        if (which == 0) e = exp_q0.pop_front();
        else            e = exp_q1.pop_front();
        checkValue($sformatf("dut%0d_rdata", which), rdata, e.rdata);
        checkValue($sformatf("dut%0d_err", which), {31'b0, err}, {31'b0, e.err});
        checkValue($sformatf("dut%0d_latency", which), 32'(cycle_cnt - e.acc),
                   (which == 0) ? 32'd3 : 32'd1);
      end
    end
  endtask

  always @(negedge clk) checkOutput(0, rsp_valid[0], rsp_rdata[0], rsp_err[0]);
  always @(negedge clk) checkOutput(1, rsp_valid[1], rsp_rdata[1], rsp_err[1]);

  // Called at a negedge; holds the request until accepted, then returns at
  // the negedge after the accepting edge with req_valid still high.
  task automatic applyStimulus(input int which, input logic wr, input logic [1:0] size,
                               input logic sgn, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata,
                               input logic exp_err, input logic push);
    exp_t e;
    int   waits = 0;
    req_valid[which]  = 1'b1;
    req_write[which]  = wr;
    req_size[which]   = size;
    req_signed[which] = sgn;
    req_addr[which]   = addr;
    req_wdata[which]  = wdata;
    while (req_ready[which] !== 1'b1 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (req_ready[which] !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL dut%0d_ready_timeout actual=0 required=1", which);
    end else begin
      if (push) begin
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.acc   = cycle_cnt + 1;
        if (which == 0) exp_q0.push_back(e);
        else            exp_q1.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic waitDrain();
    int waits = 0;
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    checkValue("drain_pending", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      checkValue($sformatf("%s_dut%0d_ready", tag, k), {31'b0, req_ready[k]}, 32'd1);
      checkValue($sformatf("%s_dut%0d_valid", tag, k), {31'b0, rsp_valid[k]}, 32'd0);
      checkValue($sformatf("%s_dut%0d_rdata", tag, k), rsp_rdata[k], 32'd0);
      checkValue($sformatf("%s_dut%0d_err", tag, k), {31'b0, rsp_err[k]}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k]  = 1'b0;
      req_write[k]  = 1'b0;
      req_size[k]   = SZ_B;
      req_signed[k] = 1'b0;
      req_addr[k]   = 32'd0;
      req_wdata[k]  = 32'd0;
    end
    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] word store then narrow loads");
    applyStimulus(0, 1'b1, SZ_W, 1'b0, 32'd1024, 32'h11223344, 32'h0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, SZ_B, 1'b0, 32'd1025, 32'h0, 32'h00000022, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, SZ_H, 1'b0, 32'd1026, 32'h0, 32'h00003344, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, SZ_W, 1'b0, 32'd1024, 32'h0, 32'h11223344, 1'b0, 1'b1);

    $display("[TB] sign extension");
    applyStimulus(0, 1'b1, SZ_B, 1'b0, 32'd1030, 32'h00000080, 32'h0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, SZ_B, 1'b1, 32'd1030, 32'h0, 32'hFFFFFF80, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, SZ_B, 1'b0, 32'd1030, 32'h0, 32'h00000080, 1'b0, 1'b1);
    applyStimulus(0, 1'b1, SZ_H, 1'b0, 32'd1032, 32'h00008001, 32'h0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, SZ_H, 1'b1, 32'd1032, 32'h0, 32'hFFFF8001, 1'b0, 1'b1);

    $display("[TB] range errors");
    applyStimulus(0, 1'b1, SZ_W, 1'b0, 32'd1084, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, SZ_W, 1'b0, 32'd1084, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
`ifdef DMEM_ALIGN_CHECK_EN
    applyStimulus(0, 1'b0, SZ_W, 1'b0, 32'd1086, 32'h0, 32'h0, 1'b1, 1'b1);
`else
    applyStimulus(0, 1'b0, SZ_W, 1'b0, 32'd1086, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
`endif
    applyStimulus(0, 1'b0, SZ_B, 1'b0, 32'd1087, 32'h0, 32'h0000000D, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, SZ_H, 1'b0, 32'd1088, 32'h0, 32'h0, 1'b1, 1'b1);
    applyStimulus(0, 1'b0, SZ_W, 1'b0, 32'd1020, 32'h0, 32'h0, 1'b1, 1'b1);
    applyStimulus(0, 1'b1, SZ_W, 1'b0, 32'd1088, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);
    applyStimulus(0, 1'b0, SZ_R, 1'b0, 32'd1024, 32'h0, 32'h0, 1'b1, 1'b1);
    applyStimulus(0, 1'b0, SZ_W, 1'b0, 32'd1024, 32'h0, 32'h11223344, 1'b0, 1'b1);

    $display("[TB] alignment");
`ifdef DMEM_ALIGN_CHECK_EN
    applyStimulus(0, 1'b1, SZ_H, 1'b0, 32'd1025, 32'h0000AABB, 32'h0, 1'b1, 1'b1);
    applyStimulus(0, 1'b0, SZ_W, 1'b0, 32'd1024, 32'h0, 32'h11223344, 1'b0, 1'b1);
`else
    applyStimulus(0, 1'b1, SZ_H, 1'b0, 32'd1025, 32'h0000AABB, 32'h0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, SZ_H, 1'b0, 32'd1024, 32'h0, 32'h0000AABB, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, SZ_W, 1'b0, 32'd1024, 32'h0, 32'hAABB3344, 1'b0, 1'b1);
`endif
    waitDrain();

    $display("[TB] back-to-back with no wait states");
    for (int i = 0; i < 4; i++) begin
      checkValue($sformatf("b2b_store%0d_ready", i), {31'b0, req_ready[1]}, 32'd1);
      applyStimulus(1, 1'b1, SZ_W, 1'b0, 32'(1024 + 4 * i), 32'hA0A1A2A3 + 32'(i) * 32'h10101010,
                    32'h0, 1'b0, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      checkValue($sformatf("b2b_load%0d_ready", i), {31'b0, req_ready[1]}, 32'd1);
      applyStimulus(1, 1'b0, SZ_W, 1'b0, 32'(1024 + 4 * i), 32'h0,
                    32'hA0A1A2A3 + 32'(i) * 32'h10101010, 1'b0, 1'b1);
    end
    waitDrain();

    $display("[TB] reset in the middle of a store");
    applyStimulus(0, 1'b1, SZ_W, 1'b0, 32'd1040, 32'h01020304, 32'h0, 1'b0, 1'b1);
    waitDrain();
    applyStimulus(0, 1'b1, SZ_W, 1'b0, 32'd1040, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    req_valid[0] = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkResetOutputs("midreset");
    rst = 1'b1;
    repeat (5) @(negedge clk);
    applyStimulus(0, 1'b0, SZ_W, 1'b0, 32'd1040, 32'h0, 32'h01020304, 1'b0, 1'b1);
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
